// File: rtl/fib_serial_gen.sv
// Bit-serial Fibonacci generator: one full adder, LSB-first, WIDTH add cycles
// per iteration. Results wrap modulo 2^WIDTH; overflow is sticky for the run.
module fib_serial_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] fib,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_UPDATE, S_DONE} state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_a, r_b, r_a_cp, r_b_cp, r_sum, r_fib;
  logic [WIDTH-1:0] w_fib_ld;
  logic             r_carry, r_ovf;
  logic [CW-1:0]    r_bit;
  logic [5:0]       r_n, r_iter, w_iter_nx;
  logic             w_s, w_co, w_last_bit;

  // The single full adder, fed from the LSBs of the a/b shift registers.
  assign w_s        = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_co       = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_last_bit = (r_bit == LAST_BIT);
  assign w_iter_nx  = r_iter + 6'd1;

  // b starts at 1, so n=0 has to be forced rather than read from b.
  assign w_fib_ld = (r_n == 6'd0) ? '0 :
                    (r_n == 6'd1) ? WIDTH'(1) : r_b;

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign fib      = done ? w_fib_ld : r_fib;
  assign overflow = r_ovf;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nx = (n < 6'd2) ? S_DONE : S_ADD;
      S_ADD:    if (w_last_bit) w_state_nx = S_UPDATE;
      S_UPDATE: w_state_nx = (w_iter_nx < (r_n - 6'd1)) ? S_ADD : S_DONE;
      S_DONE:   w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_a_cp  <= '0;
      r_b_cp  <= '0;
      r_sum   <= '0;
      r_fib   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_bit   <= '0;
      r_n     <= '0;
      r_iter  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_n     <= n;
          r_a     <= '0;
          r_b     <= WIDTH'(1);
          r_a_cp  <= '0;
          r_b_cp  <= '0;
          r_sum   <= '0;
          r_carry <= 1'b0;
          r_ovf   <= 1'b0;
          r_bit   <= '0;
          r_iter  <= '0;
        end
        S_ADD: begin
          // Shifted-out operand bits land in the copies, rebuilding the old values.
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_a_cp  <= {r_a[0], r_a_cp[WIDTH-1:1]};
          r_b_cp  <= {r_b[0], r_b_cp[WIDTH-1:1]};
          r_carry <= w_co;
          r_bit   <= w_last_bit ? '0 : r_bit + CW'(1);
          if (w_last_bit && w_co) r_ovf <= 1'b1;
        end
        S_UPDATE: begin
          r_a     <= r_b_cp;
          r_b     <= r_sum;
          r_carry <= 1'b0;
          r_iter  <= w_iter_nx;
        end
        S_DONE: r_fib <= w_fib_ld;
        default: ;
      endcase
    end
  end

endmodule
